// File: rtl/pb_event_pkg.sv
// Shared definitions for the push-button event decoder: state encodings and
// default tick thresholds.
package pb_event_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } pb_state_t;

    localparam int LONG_TICKS_DEF   = 16;
    localparam int REPEAT_TICKS_DEF = 4;
    localparam int CNT_W_DEF        = 8;

endpackage

// File: rtl/pb_edge.sv
// Edge detector for the active-low debounced button level. prev resets to 1
// so a button already held through reset still yields a press edge.
module pb_edge (
    input  logic clk,
    input  logic resetb,
    input  logic clean,
    output logic fall,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) prev <= 1'b1;
        else         prev <= clean;
    end

    assign fall = prev & ~clean;
    assign rise = ~prev & clean;

endmodule

// File: rtl/pb_event.sv
// Push-button event decoder: press / release / long-press / auto-repeat pulses
// plus hold duration in slowref ticks. The release pulse port is named
// 'released' because 'release' is a reserved word.
module pb_event
    import pb_event_pkg::*;
#(
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             slowref,
    input  logic             clean,
    output logic             press,
    output logic             released,
    output logic             long_press,
    output logic             rpt,
    output logic             held,
    output logic [CNT_W-1:0] held_ticks
);

    localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] RPT_C   = CNT_W'(REPEAT_TICKS);
    localparam logic [CNT_W-1:0] DUR_MAX = '1;

    pb_state_t        state, state_nx;
    logic [CNT_W-1:0] tick_cnt, tick_nx, tick_inc;
    logic [CNT_W-1:0] dur_cnt, dur_nx, dur_inc;
    logic [CNT_W-1:0] held_ticks_nx;
    logic             press_nx, rel_nx, long_nx, rpt_nx, held_nx;
    logic             fall, rise;

    pb_edge u_edge (
        .clk    (clk),
        .resetb (resetb),
        .clean  (clean),
        .fall   (fall),
        .rise   (rise)
    );

    assign tick_inc = tick_cnt + CNT_W'(1);
    assign dur_inc  = (dur_cnt == DUR_MAX) ? dur_cnt : dur_cnt + CNT_W'(1);

    // A release edge wins over a coincident strobe, so the strobe is neither
    // counted nor allowed to fire long_press/rpt.
    always_comb begin
        state_nx      = state;
        tick_nx       = tick_cnt;
        dur_nx        = dur_cnt;
        held_ticks_nx = held_ticks;
        held_nx       = held;
        press_nx      = 1'b0;
        rel_nx        = 1'b0;
        long_nx       = 1'b0;
        rpt_nx        = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nx = PRESSED;
                    press_nx = 1'b1;
                    held_nx  = 1'b1;
                    tick_nx  = '0;
                    dur_nx   = '0;
                end
            end
            PRESSED, REPEAT: begin
                if (rise) begin
                    state_nx      = IDLE;
                    rel_nx        = 1'b1;
                    held_nx       = 1'b0;
                    held_ticks_nx = dur_cnt;
                end else if (slowref) begin
                    dur_nx  = dur_inc;
                    tick_nx = tick_inc;
                    if (state == PRESSED && tick_inc == LONG_C) begin
                        long_nx  = 1'b1;
                        tick_nx  = '0;
                        state_nx = REPEAT;
                    end else if (state == REPEAT && tick_inc == RPT_C) begin
                        rpt_nx  = 1'b1;
                        tick_nx = '0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                held_nx  = 1'b0;
                tick_nx  = '0;
                dur_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            dur_cnt    <= '0;
            held_ticks <= '0;
            held       <= 1'b0;
            press      <= 1'b0;
            released   <= 1'b0;
            long_press <= 1'b0;
            rpt        <= 1'b0;
        end else begin
            state      <= state_nx;
            tick_cnt   <= tick_nx;
            dur_cnt    <= dur_nx;
            held_ticks <= held_ticks_nx;
            held       <= held_nx;
            press      <= press_nx;
            released   <= rel_nx;
            long_press <= long_nx;
            rpt        <= rpt_nx;
        end
    end

endmodule

// File: doc/pb_event.md
# pb_event

Push-button event decoder on the consumer side of the debounced button level. It takes the active-low debounced level (idle 1, pressed 0) and the shared 8–32 Hz `slowref` strobe, and converts them into one-clock event pulses: press, release, long-press and auto-repeat. On each release it also reports the hold duration in strobe ticks. The lift controller's floor-call and door-hold logic consume its outputs instead of raw levels.

## Interface
- `LONG_TICKS`, default 16: `slowref` strobes held before `long_press` fires; legal range 1..2^CNT_W-1.
- `REPEAT_TICKS`, default 4: `slowref` strobes between `rpt` pulses after `long_press`; legal range 1..2^CNT_W-1.
- `CNT_W`, default 8: width of the tick counter and of `held_ticks`.
- `clk`, in, 1: system clock.
- `resetb`, in, 1: asynchronous, active-low reset.
- `slowref`, in, 1: one-`clk`-wide reference strobe, 8–32 Hz.
- `clean`, in, 1: debounced button level, active-low, synchronous to `clk`.
- `press`, out, 1: one-cycle pulse on press.
- `release`, out, 1: one-cycle pulse on release.
- `long_press`, out, 1: one-cycle pulse when the hold reaches `LONG_TICKS`.
- `rpt`, out, 1: one-cycle auto-repeat pulse.
- `held`, out, 1: level, 1 while the button is pressed (from `press` to `release`).
- `held_ticks`, out, CNT_W: strobes counted during the last completed hold, saturating; updated on `release`.

## Operation
- `prev` register holds `clean` delayed by one cycle.
  - Press edge: `prev`=1 and `clean`=0.
  - Release edge: `prev`=0 and `clean`=1.
- States: IDLE, PRESSED, REPEAT.
- IDLE:
  - On a press edge, go to PRESSED, pulse `press`, clear `tick_cnt` and `dur_cnt`.
  - `slowref` is ignored.
- PRESSED:
  - Each `slowref` increments `tick_cnt` and `dur_cnt` (`dur_cnt` saturates at 2^CNT_W-1).
  - When the increment makes `tick_cnt` equal `LONG_TICKS`, pulse `long_press`, clear `tick_cnt`, go to REPEAT.
- REPEAT:
  - Each `slowref` increments `tick_cnt` and `dur_cnt`.
  - When `tick_cnt` reaches `REPEAT_TICKS`, pulse `rpt` and clear `tick_cnt`. Repeats indefinitely.
- Release edge in PRESSED or REPEAT:
  - Pulse `release` and load `held_ticks` with `dur_cnt`.
  - Drive `held` to 0 and return to IDLE.
- Precedence for simultaneous events in one cycle: release edge, then strobe.
  - A release edge coinciding with `slowref` suppresses `long_press`/`rpt` and does not count that strobe.
- A strobe in the same cycle as the press edge is not counted. Counting starts with the next strobe.
- `press`, `release`, `long_press` and `rpt` are mutually exclusive in any cycle.

## Timing
- All outputs are registered. Each event pulse is high for exactly 1 `clk`, in the cycle after the triggering edge.
- `clean` falls at cycle N: `prev` still 1 at edge N+1, so `press`=1 and `held`=1 in cycle N+1.
- The Nth counted strobe sampled at edge E gives `long_press`/`rpt` high in the cycle after E.
- `held_ticks` becomes valid in the same cycle as `release` and holds until the next `release`.
- Values on reset assertion (asynchronous, immediate):
  - State IDLE, `prev`=1.
  - All pulses, `held`, `tick_cnt`, `dur_cnt` and `held_ticks` = 0.
- Reset during a hold: the block returns to IDLE with no `release` pulse.
  - If `clean` is still 0 after reset, a fresh `press` fires one cycle after the first sampling edge, because `prev` resets to 1.
- `held_ticks` saturates at 2^CNT_W-1 and never wraps. `tick_cnt` cannot overflow, because the parameter range is bounded.

## Structure
- Shared lift header/package holds:
  - state encodings IDLE=2'd0, PRESSED=2'd1, REPEAT=2'd2;
  - defaults for `LONG_TICKS` and `REPEAT_TICKS`.
- Encoding 2'd3 is illegal and recovers to IDLE.
- One sub-module, `pb_edge`:
  - holds the `prev` register;
  - outputs `fall` and `rise` one-cycle combinational flags.
- The FSM, counters and output registers stay in `pb_event`.

## Test plan
- Reset, then `clean` held at 1 for 100 strobes: all outputs 0, state IDLE.
- `LONG_TICKS`=4. `clean`→0, release after 2 strobes: `press` at cycle N+1, no `long_press`, then `release` with `held_ticks`=2.
- `LONG_TICKS`=4, `REPEAT_TICKS`=2, hold for 9 strobes:
  - `long_press` after strobe 4;
  - `rpt` after strobes 6 and 8;
  - on release, `held_ticks`=9.
- Release edge in the same cycle as the 4th strobe (`LONG_TICKS`=4): no `long_press`, `release`=1, `held_ticks`=3.
- `CNT_W`=4, hold for 20 strobes: `held_ticks`=15, saturated.
- Assert `resetb` mid-hold with `clean`=0, then deassert:
  - no `release` pulse;
  - `press` one cycle after the first post-reset edge;
  - `held`=1.
